level_disp_scan: RTL
====================

# level_disp_scan

Scanning driver for the 8-digit seven-segment display in the counting game. It shows the current level as `L<n>-` on the left and the countdown seconds (0–15) on the right. It sits directly downstream of the game FSM, which supplies the enable, level number and seconds value. Low seconds values blink to warn the player.

## Interface
Parameters:
- SCAN_DIV, default 1000: clk cycles each digit stays selected; must be ≥ 2.
- BLINK_FRAMES, default 62: full 8-digit frames per blink half-period; must be ≥ 1.

Ports:
- clk  in  1  system clock; the block uses this single clock domain only.
- rst  in  1  reset; synchronous, active-high.
- st  in  1  display enable from the game FSM.
- num  in  2  level number (0–3).
- secs  in  4  remaining seconds (0–15).
- seg  out  8  segment bits {dp,g,f,e,d,c,b,a}, active-high, registered.
- dig  out  8  digit selects, active-low, registered; dig[0] is the rightmost digit.

## Operation
- Glyphs: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F; 'L'=38; '-'=40; blank=00. The dp bit is always 0.
- Layout:
  - idx7: 'L'.
  - idx6: digit of num.
  - idx5: '-'.
  - idx4..2: blank.
  - idx1: tens of secs; blank when secs<10.
  - idx0: units of secs.
- BCD conversion: if snap_secs≥10, tens=1 and units=snap_secs−10; otherwise tens is blank and units=snap_secs.
- Blank digits still assert their dig line; only seg=00.
- Snapshot: num/secs are latched into snap_num/snap_secs on the idle→run transition and on every idx wrap 7→0. The displayed frame never tears.
- Blink rule:
  - Applies when snap_secs ∈ {1,2,3}: during the off phase, idx1 and idx0 show seg=00.
  - secs=0 is shown as a steady '0'.
  - secs≥4 never blinks.
- States:
  - IDLE (after rst, or whenever st=0): cnt=0, idx=0, fcnt=0, phase=ON, seg=00, dig=FF.
  - RUN (st=1): scanning.
  - IDLE→RUN when st=1. RUN→IDLE on the same edge st is sampled 0; outputs go dark the following cycle.

## Timing
- Reset values: seg=8'h00, dig=8'hFF, cnt=0, idx=0, fcnt=0, phase=ON, snap_num=0, snap_secs=0, state IDLE. rst has priority over st.
- Divider in RUN:
  - cnt counts 0..SCAN_DIV−1.
  - At terminal count, cnt←0 and idx←idx+1 mod 8.
  - A frame lasts 8·SCAN_DIV cycles.
- Frame counter: on each idx 7→0 wrap, fcnt increments. When fcnt reaches BLINK_FRAMES−1, fcnt←0 and phase toggles. One blink period is 2·BLINK_FRAMES frames.
- Output latency: seg/dig are registered from the current idx/snapshot/phase, one cycle behind idx. After a st rise sampled at edge t, idx0 appears at edge t+1 and is held SCAN_DIV cycles.
- Exactly one dig bit is low in RUN at all times; there is no cycle with two bits low.
- Input changes mid-frame take effect at the start of the next frame (first idx0 output after the wrap).
- st pulse of 1 cycle: one IDLE→RUN→IDLE pass. Output: one cycle of dig=FE, then dark.
- rst mid-scan: the next cycle shows seg=00, dig=FF. Scanning resumes from idx0 with phase=ON if st is still high after rst falls.

## Test plan
Bench parameters: SCAN_DIV=4, BLINK_FRAMES=2.

- Reset/idle: rst=1 for 3 cycles, then st=0 for 50 cycles → seg=00 and dig=FF every cycle.
- Basic frame: num=2, secs=7, st=1 → dig cycles FE,FD,FB,…,7F, each held 4 cycles. seg sequence: 07, 00, 00, 00, 00, 40, 5B, 38. Period is 32 cycles.
- Two-digit secs: secs=12 → idx1 seg=06 and idx0 seg=5B. Change secs to 9 mid-frame (during idx3) → current frame still shows 12; next frame shows idx1=00 and idx0=6F.
- Blink: secs=3 → idx0 shows 4F for frames 0–1, 00 for frames 2–3, 4F again in frames 4–5. idx7 'L' (38) is unaffected throughout. secs=0 → idx0=3F in every frame.
- Enable/reset abort:
  - Drop st during idx4 → dig=FF the following cycle.
  - Raise st again → idx0 is shown first.
  - Assert rst while st=1 → next output is dig=FF, then a fresh scan from FE with phase ON.

Source files
------------

// File: rtl/level_disp_scan.sv
// level_disp_scan: 8-digit multiplexed seven-segment driver showing "L<n>-" and blinking countdown seconds.
module level_disp_scan #(
  parameter int SCAN_DIV = 1000,
  parameter int BLINK_FRAMES = 62
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       st,
  input  logic [1:0] num,
  input  logic [3:0] secs,
  output logic [7:0] seg,
  output logic [7:0] dig
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [FW-1:0] fcnt;
  logic phase;
  logic [1:0] snap_num;
  logic [3:0] snap_secs, units;
  logic tc, wrap, dark;
  logic [7:0] glyph;
  function automatic logic [7:0] digit(input logic [3:0] d);
    case (d)
      4'd0: digit = 8'h3F;
      4'd1: digit = 8'h06;
      4'd2: digit = 8'h5B;
      4'd3: digit = 8'h4F;
      4'd4: digit = 8'h66;
      4'd5: digit = 8'h6D;
      4'd6: digit = 8'h7D;
      4'd7: digit = 8'h07;
      4'd8: digit = 8'h7F;
      4'd9: digit = 8'h6F;
      default: digit = 8'h00;
    endcase
  endfunction
  always_comb begin
    state_nx = st ? RUN : IDLE;
    tc = cnt == CW'(SCAN_DIV - 1);
    wrap = tc && idx == 3'd7;
    units = snap_secs >= 4'd10 ? snap_secs - 4'd10 : snap_secs;
    dark = !phase && snap_secs != 4'd0 && snap_secs < 4'd4;
    glyph = idx == 3'd7 ? 8'h38 :
            idx == 3'd6 ? digit({2'b00, snap_num}) :
            idx == 3'd5 ? 8'h40 :
            idx == 3'd1 && snap_secs >= 4'd10 ? 8'h06 :
            idx == 3'd0 && !dark ? digit(units) : 8'h00;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      fcnt <= '0;
      phase <= 1'b1;
      snap_num <= '0;
      snap_secs <= '0;
      seg <= 8'h00;
      dig <= 8'hFF;
    end else begin
      state <= state_nx;
      seg <= state == RUN ? glyph : 8'h00;
      dig <= state == RUN ? ~(8'd1 << idx) : 8'hFF;
      if (state == RUN && st) begin
        cnt <= tc ? '0 : cnt + CW'(1);
        if (tc) idx <= idx + 3'd1;
        // new inputs are sampled only between frames so a frame never tears
        if (wrap) begin
          snap_num <= num;
          snap_secs <= secs;
          fcnt <= fcnt == FW'(BLINK_FRAMES - 1) ? '0 : fcnt + FW'(1);
          if (fcnt == FW'(BLINK_FRAMES - 1)) phase <= ~phase;
        end
      end else begin
        cnt <= '0;
        idx <= '0;
        fcnt <= '0;
        phase <= 1'b1;
        if (state == IDLE && st) begin
          snap_num <= num;
          snap_secs <= secs;
        end
      end
    end
  end
endmodule
